nri_divider: RTL

NRI_DIVIDER -- requirements
Module: nri_divider

---
 rtl/nri_divider.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/nri_divider.sv
// Iterative radix-2 non-restoring divider for DIV/DIVU/REM/REMU with valid/ready handshakes.
// Divide-by-zero and signed overflow bypass the iteration and complete one cycle after accept.
module nri_divider #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   qd_q, qd_d;
    logic [XLEN-1:0]   dvm_q, dvm_d;
    logic [XLEN:0]     pr_q, pr_d;
    logic              qsign_q, qsign_d;
    logic              rsign_q, rsign_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              in_signed;
    logic              a_neg;
    logic              b_neg;
    logic              div_zero;
    logic              sgn_ovf;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     pr_step;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   quo_out;
    logic [XLEN-1:0]   rem_out;

    always_comb begin
        in_signed = ~i_op[0];
        a_neg     = in_signed & i_dividend[XLEN-1];
        b_neg     = in_signed & i_divisor[XLEN-1];
        div_zero  = (i_divisor == '0);
        sgn_ovf   = in_signed && (i_dividend == {1'b1, {(XLEN-1){1'b0}}}) && (i_divisor == '1);

        // qd holds the dividend magnitude; quotient bits shift in as dividend bits shift out
        shifted   = {pr_q[XLEN-1:0], qd_q[XLEN-1]};
        pr_step   = pr_q[XLEN] ? (shifted + {1'b0, dvm_q}) : (shifted - {1'b0, dvm_q});

        rem_fix   = pr_q[XLEN] ? (pr_q[XLEN-1:0] + dvm_q) : pr_q[XLEN-1:0];
        quo_out   = (qsign_q & ~op_q[0]) ? (~qd_q + 1'b1) : qd_q;
        rem_out   = (rsign_q & ~op_q[0]) ? (~rem_fix + 1'b1) : rem_fix;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        qd_d     = qd_q;
        dvm_d    = dvm_q;
        pr_d     = pr_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    op_d    = i_op;
                    qd_d    = a_neg ? (~i_dividend + 1'b1) : i_dividend;
                    dvm_d   = b_neg ? (~i_divisor + 1'b1) : i_divisor;
                    pr_d    = '0;
                    cnt_d   = '0;
                    qsign_d = a_neg ^ b_neg;
                    rsign_d = a_neg;
                    if (div_zero) begin
                        result_d = i_op[1] ? i_dividend : '1;
                        state_d  = ST_DONE;
                    end else if (sgn_ovf) begin
                        result_d = i_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                pr_d = pr_step;
                qd_d = {qd_q[XLEN-2:0], ~pr_step[XLEN]};
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_FIX: begin
                result_d = op_q[1] ? rem_out : quo_out;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            qd_q     <= '0;
            dvm_q    <= '0;
            pr_q     <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            qd_q     <= qd_d;
            dvm_q    <= dvm_d;
            pr_q     <= pr_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_busy   = (state_q != ST_IDLE);
    assign o_valid  = (state_q == ST_DONE);
    assign o_result = result_q;

endmodule
